// File: rtl/sram_pkg.sv
// Shared definitions for the banked scratchpad SRAM controller:
// macro geometry, the default error read data, the OBI response
// struct and a byte-enable merge helper.
package sram_pkg;

  // One sky130 32x512 macro: 512 words of 32 bits, 2048 bytes.
  localparam int unsigned LOG_BLOCK_WORDS_C = 9;
  localparam int unsigned BLOCK_BYTES_C     = 2048;

  // Read data returned with every error response.
  localparam logic [31:0] ERR_RDATA_C = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        rvalid;
    logic        err;
    logic [31:0] rdata;
  } obi_rsp_t;

  // Replace the bytes of old_w selected by be with the bytes of new_w.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_w;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        res[8*k +: 8] = new_w[8*k +: 8];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_port_decode.sv
// Per-port address decode and response state. Checks that the byte
// address lies inside the SRAM window and is word aligned, splits the
// window offset into bank and word index, and registers the response
// flags and bank select of each granted request for the following cycle.
module sram_port_decode
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned NUM_BLOCKS      = 24,
  parameter int unsigned LOG_BLOCK_WORDS = LOG_BLOCK_WORDS_C,
  parameter int unsigned BANK_W          = 5
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic [31:0]                addr_i,
  input  logic                       gnt_i,
  output logic                       legal_o,
  output logic [BANK_W-1:0]          bank_o,
  output logic [LOG_BLOCK_WORDS-1:0] word_o,
  output logic                       rvalid_o,
  output logic                       err_o,
  output logic [BANK_W-1:0]          bank_sel_o
);

  // Window size kept in 33 bits so a window ending at 2^32 still compares.
  localparam logic [32:0] WINDOW_C = 33'(NUM_BLOCKS) << (LOG_BLOCK_WORDS + 2);

  logic [31:0]       offset_s;
  logic              rvalid_r;
  logic              err_r;
  logic [BANK_W-1:0] bank_sel_r;

  // Offset wraps for addresses below BASE_ADDR, so one unsigned compare
  // covers both window limits.
  assign offset_s = addr_i - BASE_ADDR;
  assign legal_o  = ({1'b0, offset_s} < WINDOW_C) && (addr_i[1:0] == 2'b00);
  assign bank_o   = offset_s[LOG_BLOCK_WORDS+2 +: BANK_W];
  assign word_o   = offset_s[LOG_BLOCK_WORDS+1:2];

  // Response state: one rvalid the cycle after each grant, flagged as an
  // error when the granted address was illegal.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_r   <= 1'b0;
      err_r      <= 1'b0;
      bank_sel_r <= '0;
    end else begin
      rvalid_r <= gnt_i;
      err_r    <= gnt_i && !legal_o;
      if (gnt_i) begin
        bank_sel_r <= bank_o;
      end
    end
  end

  assign rvalid_o   = rvalid_r;
  assign err_o      = err_r;
  assign bank_sel_o = bank_sel_r;

endmodule

// File: rtl/sram_bank_ctrl.sv
// Dual-port OBI scratchpad controller banked over NUM_BLOCKS 1rw1r
// 32x512 SRAM macros. The data port reads and writes, the instruction
// port only reads. Illegal (out of window or misaligned) accesses are
// granted and answered with an error, and counted in a saturating counter.
// A data write and instruction read of the same word in the same cycle
// stall the instruction port for one cycle, unless SRAM_RAW_FWD_EN is
// defined, in which case the written bytes are forwarded instead.
module sram_bank_ctrl
  import sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned NUM_BLOCKS      = 24,
  parameter int unsigned LOG_BLOCK_WORDS = LOG_BLOCK_WORDS_C,
  parameter logic [31:0] ERR_RDATA       = ERR_RDATA_C,
  parameter int unsigned CNT_W           = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             d_req_i,
  output logic             d_gnt_o,
  input  logic [31:0]      d_addr_i,
  input  logic             d_we_i,
  input  logic [3:0]       d_be_i,
  input  logic [31:0]      d_wdata_i,
  output logic             d_rvalid_o,
  output logic             d_err_o,
  output logic [31:0]      d_rdata_o,
  input  logic             i_req_i,
  output logic             i_gnt_o,
  input  logic [31:0]      i_addr_i,
  output logic             i_rvalid_o,
  output logic             i_err_o,
  output logic [31:0]      i_rdata_o,
  output logic             illegal_memory_o,
  output logic [CNT_W-1:0] illegal_cnt_o
);

  localparam int unsigned BANK_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
  localparam int unsigned WORDS  = 1 << LOG_BLOCK_WORDS;

  logic                       d_gnt_s, i_gnt_s;
  logic                       d_legal_s, i_legal_s;
  logic [BANK_W-1:0]          d_bank_s, i_bank_s;
  logic [LOG_BLOCK_WORDS-1:0] d_word_s, i_word_s;
  logic                       d_rvalid_s, i_rvalid_s;
  logic                       d_err_s, i_err_s;
  logic [BANK_W-1:0]          d_sel_s, i_sel_s;
  logic                       conflict_s;
  logic                       d_cs_s, i_cs_s;
  logic [31:0]                i_mem_word_s;
  obi_rsp_t                   d_rsp_s, i_rsp_s;
  logic [1:0]                 illegal_inc_s;
  logic [CNT_W:0]             cnt_sum_s;
  logic [CNT_W-1:0]           cnt_r;
  logic                       illegal_r;

  // Macro contents and per-macro registered read ports.
  logic [31:0] mem_r    [NUM_BLOCKS][WORDS];
  logic [31:0] d_dout_r [NUM_BLOCKS];
  logic [31:0] i_dout_r [NUM_BLOCKS];

  sram_port_decode #(
    .BASE_ADDR      (BASE_ADDR),
    .NUM_BLOCKS     (NUM_BLOCKS),
    .LOG_BLOCK_WORDS(LOG_BLOCK_WORDS),
    .BANK_W         (BANK_W)
  ) u_d_decode (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .addr_i    (d_addr_i),
    .gnt_i     (d_gnt_s),
    .legal_o   (d_legal_s),
    .bank_o    (d_bank_s),
    .word_o    (d_word_s),
    .rvalid_o  (d_rvalid_s),
    .err_o     (d_err_s),
    .bank_sel_o(d_sel_s)
  );

  sram_port_decode #(
    .BASE_ADDR      (BASE_ADDR),
    .NUM_BLOCKS     (NUM_BLOCKS),
    .LOG_BLOCK_WORDS(LOG_BLOCK_WORDS),
    .BANK_W         (BANK_W)
  ) u_i_decode (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .addr_i    (i_addr_i),
    .gnt_i     (i_gnt_s),
    .legal_o   (i_legal_s),
    .bank_o    (i_bank_s),
    .word_o    (i_word_s),
    .rvalid_o  (i_rvalid_s),
    .err_o     (i_err_s),
    .bank_sel_o(i_sel_s)
  );

  // Same-word write/read in one cycle: the macro cannot return the new
  // value on its read port in that cycle.
  assign conflict_s = d_req_i && d_we_i && d_legal_s &&
                      i_req_i && i_legal_s &&
                      (d_bank_s == i_bank_s) && (d_word_s == i_word_s);

  assign d_gnt_s = d_req_i;
`ifdef SRAM_RAW_FWD_EN
  assign i_gnt_s = i_req_i;
`else
  assign i_gnt_s = i_req_i && !conflict_s;
`endif

  // Illegal accesses are granted but never select a macro.
  assign d_cs_s = d_gnt_s && d_legal_s;
  assign i_cs_s = i_gnt_s && i_legal_s;

  // Macro array: data port read/write with byte enables, instruction port
  // read-only; read data is registered and reflects the pre-write word.
  always_ff @(posedge clk_i) begin
    if (d_cs_s) begin
      if (d_we_i) begin
        mem_r[d_bank_s][d_word_s] <= merge_bytes(mem_r[d_bank_s][d_word_s], d_wdata_i, d_be_i);
      end
      d_dout_r[d_bank_s] <= mem_r[d_bank_s][d_word_s];
    end
    if (i_cs_s) begin
      i_dout_r[i_bank_s] <= mem_r[i_bank_s][i_word_s];
    end
  end

`ifdef SRAM_RAW_FWD_EN
  logic        fwd_hit_r;
  logic [31:0] fwd_wdata_r;
  logic [3:0]  fwd_be_r;

  // Capture the conflicting write so its bytes can overlay the stale read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fwd_hit_r   <= 1'b0;
      fwd_wdata_r <= 32'h0000_0000;
      fwd_be_r    <= 4'h0;
    end else begin
      fwd_hit_r <= conflict_s;
      if (conflict_s) begin
        fwd_wdata_r <= d_wdata_i;
        fwd_be_r    <= d_be_i;
      end
    end
  end

  assign i_mem_word_s = fwd_hit_r ? merge_bytes(i_dout_r[i_sel_s], fwd_wdata_r, fwd_be_r)
                                  : i_dout_r[i_sel_s];
`else
  assign i_mem_word_s = i_dout_r[i_sel_s];
`endif

  // Response assembly: rdata is zero outside rvalid and ERR_RDATA on error.
  always_comb begin
    d_rsp_s = '0;
    i_rsp_s = '0;
    if (d_rvalid_s) begin
      d_rsp_s.rvalid = 1'b1;
      d_rsp_s.err    = d_err_s;
      d_rsp_s.rdata  = d_err_s ? ERR_RDATA : d_dout_r[d_sel_s];
    end else begin
      d_rsp_s = '0;
    end
    if (i_rvalid_s) begin
      i_rsp_s.rvalid = 1'b1;
      i_rsp_s.err    = i_err_s;
      i_rsp_s.rdata  = i_err_s ? ERR_RDATA : i_mem_word_s;
    end else begin
      i_rsp_s = '0;
    end
  end

  assign illegal_inc_s = {1'b0, d_gnt_s && !d_legal_s} + {1'b0, i_gnt_s && !i_legal_s};
  assign cnt_sum_s     = {1'b0, cnt_r} + {{(CNT_W-1){1'b0}}, illegal_inc_s};

  // Saturating illegal-access counter and the error pulse that lines up
  // with the error responses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r     <= '0;
      illegal_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_sum_s[CNT_W] ? '1 : cnt_sum_s[CNT_W-1:0];
      illegal_r <= |illegal_inc_s;
    end
  end

  assign d_gnt_o          = d_gnt_s;
  assign i_gnt_o          = i_gnt_s;
  assign d_rvalid_o       = d_rsp_s.rvalid;
  assign d_err_o          = d_rsp_s.err;
  assign d_rdata_o        = d_rsp_s.rdata;
  assign i_rvalid_o       = i_rsp_s.rvalid;
  assign i_err_o          = i_rsp_s.err;
  assign i_rdata_o        = i_rsp_s.rdata;
  assign illegal_memory_o = illegal_r;
  assign illegal_cnt_o    = cnt_r;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Directed bench for sram_bank_ctrl (default parameters, 24 macros).
// Inputs change 1 time unit after the rising edge; grants are sampled
// 1 unit later, responses 1 unit after the following rising edge.
module tb_sram_bank_ctrl;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        d_req_i, d_we_i;
  logic [31:0] d_addr_i, d_wdata_i;
  logic [3:0]  d_be_i;
  logic        d_gnt_o, d_rvalid_o, d_err_o;
  logic [31:0] d_rdata_o;
  logic        i_req_i;
  logic [31:0] i_addr_i;
  logic        i_gnt_o, i_rvalid_o, i_err_o;
  logic [31:0] i_rdata_o;
  logic        illegal_memory_o;
  logic [7:0]  illegal_cnt_o;

  int errors = 0;
  int checks = 0;

  sram_bank_ctrl dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .d_req_i         (d_req_i),
    .d_gnt_o         (d_gnt_o),
    .d_addr_i        (d_addr_i),
    .d_we_i          (d_we_i),
    .d_be_i          (d_be_i),
    .d_wdata_i       (d_wdata_i),
    .d_rvalid_o      (d_rvalid_o),
    .d_err_o         (d_err_o),
    .d_rdata_o       (d_rdata_o),
    .i_req_i         (i_req_i),
    .i_gnt_o         (i_gnt_o),
    .i_addr_i        (i_addr_i),
    .i_rvalid_o      (i_rvalid_o),
    .i_err_o         (i_err_o),
    .i_rdata_o       (i_rdata_o),
    .illegal_memory_o(illegal_memory_o),
    .illegal_cnt_o   (illegal_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic idle();
    d_req_i = 1'b0; d_we_i = 1'b0; d_be_i = 4'h0;
    d_addr_i = 32'h0; d_wdata_i = 32'h0;
    i_req_i = 1'b0; i_addr_i = 32'h0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic d_set(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    d_req_i = 1'b1; d_we_i = we; d_addr_i = addr; d_wdata_i = wdata; d_be_i = be;
  endtask

  task automatic check_all_zero(input string tag);
    logic [31:0] agg;
    agg = {d_gnt_o, i_gnt_o, d_rvalid_o, d_err_o, i_rvalid_o, i_err_o,
           illegal_memory_o, 17'h0, illegal_cnt_o} | d_rdata_o | i_rdata_o;
    checks++;
    if (agg !== 32'h0) begin
      errors++;
      $display("FAIL %s outputs got=%h exp=00000000", tag, agg);
    end
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    #3;
    check_all_zero("reset_asserted");
    step();
    rst_ni = 1'b1;
    step();
    check_all_zero("reset_first_cycle");
  endtask

  task automatic test_write_ifetch();
    d_set(1'b1, 32'h8000_0010, 32'h1234_5678, 4'hF);
    #1;
    checks++; if (d_gnt_o !== 1'b1) begin errors++; $display("FAIL wr_gnt got=%b exp=1", d_gnt_o); end
    step();
    checks++; if ({d_rvalid_o, d_err_o} !== 2'b10) begin errors++; $display("FAIL wr_rsp got=%b exp=10", {d_rvalid_o, d_err_o}); end
    idle();
    i_req_i = 1'b1; i_addr_i = 32'h8000_0010;
    #1;
    checks++; if (i_gnt_o !== 1'b1) begin errors++; $display("FAIL if_gnt got=%b exp=1", i_gnt_o); end
    step();
    checks++; if ({i_rvalid_o, i_err_o} !== 2'b10) begin errors++; $display("FAIL if_rsp got=%b exp=10", {i_rvalid_o, i_err_o}); end
    checks++; if (i_rdata_o !== 32'h1234_5678) begin errors++; $display("FAIL if_rdata got=%h exp=12345678", i_rdata_o); end
    checks++; if (d_rdata_o !== 32'h0) begin errors++; $display("FAIL d_rdata_idle got=%h exp=0", d_rdata_o); end
    idle();
    step();
    checks++; if ({i_rvalid_o, i_rdata_o} !== 33'h0) begin errors++; $display("FAIL if_idle got=%b/%h exp=0/0", i_rvalid_o, i_rdata_o); end
  endtask

  task automatic test_byte_enable();
    d_set(1'b1, 32'h8000_0804, 32'h1234_5678, 4'hF);
    step();
    d_set(1'b1, 32'h8000_0804, 32'hFFFF_AAFF, 4'b0010);
    step();
    d_set(1'b1, 32'h8000_0804, 32'hFFFF_FFFF, 4'b0000);
    step();
    checks++; if ({d_rvalid_o, d_err_o} !== 2'b10) begin errors++; $display("FAIL be0_rsp got=%b exp=10", {d_rvalid_o, d_err_o}); end
    d_set(1'b0, 32'h8000_0804, 32'h0, 4'hF);
    step();
    checks++; if (d_rdata_o !== 32'h1234_AA78) begin errors++; $display("FAIL be_rdata got=%h exp=1234aa78", d_rdata_o); end
    idle();
  endtask

  task automatic test_illegal();
    d_set(1'b0, 32'h8000_C000, 32'h0, 4'hF);
    #1;
    checks++; if (d_gnt_o !== 1'b1) begin errors++; $display("FAIL ill_gnt got=%b exp=1", d_gnt_o); end
    step();
    checks++; if ({d_rvalid_o, d_err_o, illegal_memory_o} !== 3'b111) begin errors++; $display("FAIL ill_rsp got=%b exp=111", {d_rvalid_o, d_err_o, illegal_memory_o}); end
    checks++; if (d_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ill_rdata got=%h exp=deadbeef", d_rdata_o); end
    checks++; if (illegal_cnt_o !== 8'd1) begin errors++; $display("FAIL ill_cnt1 got=%0d exp=1", illegal_cnt_o); end
    d_set(1'b0, 32'h8000_0002, 32'h0, 4'hF);
    step();
    checks++; if ({d_err_o, illegal_cnt_o} !== {1'b1, 8'd2}) begin errors++; $display("FAIL misalign got=%b/%0d exp=1/2", d_err_o, illegal_cnt_o); end
    d_set(1'b0, 32'h8000_BFFC, 32'h0, 4'hF);
    step();
    checks++; if ({d_rvalid_o, d_err_o, illegal_memory_o, illegal_cnt_o} !== {3'b100, 8'd2}) begin errors++; $display("FAIL last_word got=%b/%0d exp=100/2", {d_rvalid_o, d_err_o, illegal_memory_o}, illegal_cnt_o); end
    d_set(1'b0, 32'h7FFF_FFFC, 32'h0, 4'hF);
    i_req_i = 1'b1; i_addr_i = 32'h8000_C000;
    step();
    checks++; if ({d_err_o, i_err_o, illegal_cnt_o} !== {2'b11, 8'd4}) begin errors++; $display("FAIL dual_ill got=%b/%0d exp=11/4", {d_err_o, i_err_o}, illegal_cnt_o); end
    checks++; if (i_rdata_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL i_ill_rdata got=%h exp=deadbeef", i_rdata_o); end
    idle();
    step();
    checks++; if ({illegal_memory_o, d_rvalid_o} !== 2'b00) begin errors++; $display("FAIL ill_pulse_end got=%b exp=00", {illegal_memory_o, d_rvalid_o}); end
  endtask

  task automatic test_conflict();
    logic [31:0] wd  [2] = '{32'hAABB_CCDD, 32'h0000_0011};
    logic [3:0]  be  [2] = '{4'hF, 4'b0001};
    logic [31:0] exp [2] = '{32'hAABB_CCDD, 32'hAABB_CC11};
    for (int v = 0; v < 2; v++) begin
      d_set(1'b1, 32'h8000_0020, wd[v], be[v]);
      i_req_i = 1'b1; i_addr_i = 32'h8000_0020;
      #1;
`ifdef SRAM_RAW_FWD_EN
      checks++; if (i_gnt_o !== 1'b1) begin errors++; $display("FAIL cf_gnt v%0d got=%b exp=1", v, i_gnt_o); end
      step();
      d_req_i = 1'b0; i_req_i = 1'b0;
      checks++; if ({i_rvalid_o, i_rdata_o} !== {1'b1, exp[v]}) begin errors++; $display("FAIL cf_fwd v%0d got=%b/%h exp=1/%h", v, i_rvalid_o, i_rdata_o, exp[v]); end
`else
      checks++; if (i_gnt_o !== 1'b0) begin errors++; $display("FAIL cf_stall v%0d got=%b exp=0", v, i_gnt_o); end
      step();
      d_req_i = 1'b0;
      checks++; if (i_rvalid_o !== 1'b0) begin errors++; $display("FAIL cf_norsp v%0d got=%b exp=0", v, i_rvalid_o); end
      #1;
      checks++; if (i_gnt_o !== 1'b1) begin errors++; $display("FAIL cf_regrant v%0d got=%b exp=1", v, i_gnt_o); end
      step();
      i_req_i = 1'b0;
      checks++; if ({i_rvalid_o, i_rdata_o} !== {1'b1, exp[v]}) begin errors++; $display("FAIL cf_rdata v%0d got=%b/%h exp=1/%h", v, i_rvalid_o, i_rdata_o, exp[v]); end
`endif
      step();
    end
    d_set(1'b0, 32'h8000_0020, 32'h0, 4'hF);
    i_req_i = 1'b1; i_addr_i = 32'h8000_0020;
    #1;
    checks++; if (i_gnt_o !== 1'b1) begin errors++; $display("FAIL rd_rd_gnt got=%b exp=1", i_gnt_o); end
    step();
    checks++; if ({d_rdata_o, i_rdata_o} !== {32'hAABB_CC11, 32'hAABB_CC11}) begin errors++; $display("FAIL rd_rd got=%h/%h exp=aabbcc11", d_rdata_o, i_rdata_o); end
    d_set(1'b1, 32'h8000_0024, 32'h5555_5555, 4'hF);
    #1;
    checks++; if (i_gnt_o !== 1'b1) begin errors++; $display("FAIL other_word_gnt got=%b exp=1", i_gnt_o); end
    step();
    checks++; if (i_rdata_o !== 32'hAABB_CC11) begin errors++; $display("FAIL other_word got=%h exp=aabbcc11", i_rdata_o); end
    idle();
  endtask

  task automatic test_back_to_back();
    d_set(1'b0, 32'h8000_0010, 32'h0, 4'hF);
    i_req_i = 1'b1; i_addr_i = 32'h8000_0804;
    step();
    checks++; if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL b2b_d0 got=%b/%h exp=1/12345678", d_rvalid_o, d_rdata_o); end
    checks++; if ({i_rvalid_o, i_rdata_o} !== {1'b1, 32'h1234_AA78}) begin errors++; $display("FAIL b2b_i0 got=%b/%h exp=1/1234aa78", i_rvalid_o, i_rdata_o); end
    d_addr_i = 32'h8000_0024; i_addr_i = 32'h8000_0010;
    step();
    checks++; if ({d_rvalid_o, d_rdata_o} !== {1'b1, 32'h5555_5555}) begin errors++; $display("FAIL b2b_d1 got=%b/%h exp=1/55555555", d_rvalid_o, d_rdata_o); end
    checks++; if ({i_rvalid_o, i_rdata_o} !== {1'b1, 32'h1234_5678}) begin errors++; $display("FAIL b2b_i1 got=%b/%h exp=1/12345678", i_rvalid_o, i_rdata_o); end
    idle();
    step();
  endtask

  task automatic test_reset_mid();
    d_set(1'b0, 32'h8000_0010, 32'h0, 4'hF);
    #1;
    checks++; if (d_gnt_o !== 1'b1) begin errors++; $display("FAIL rm_gnt got=%b exp=1", d_gnt_o); end
    rst_ni = 1'b0;
    idle();
    step();
    check_all_zero("reset_mid_asserted");
    #3;
    rst_ni = 1'b1;
    step();
    check_all_zero("reset_mid_released");
  endtask

  task automatic test_saturate();
    d_set(1'b0, 32'h8000_C000, 32'h0, 4'hF);
    repeat (254) @(posedge clk_i);
    #1;
    checks++; if (illegal_cnt_o !== 8'hFE) begin errors++; $display("FAIL sat_fe got=%h exp=fe", illegal_cnt_o); end
    i_req_i = 1'b1; i_addr_i = 32'h0000_0000;
    step();
    checks++; if (illegal_cnt_o !== 8'hFF) begin errors++; $display("FAIL sat_dual got=%h exp=ff", illegal_cnt_o); end
    i_req_i = 1'b0;
    repeat (45) @(posedge clk_i);
    #1;
    checks++; if ({illegal_cnt_o, illegal_memory_o} !== {8'hFF, 1'b1}) begin errors++; $display("FAIL sat_hold got=%h/%b exp=ff/1", illegal_cnt_o, illegal_memory_o); end
    idle();
    step();
  endtask

  initial begin
    test_reset();
    test_write_ifetch();
    test_byte_enable();
    test_illegal();
    test_conflict();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
